// File: rtl/instruction_fetcher.sv
// Instruction fetcher: issues fetch addresses to the instruction cache, accepts
// registered cache responses into a circular fetch queue, and presents the queue
// head to the decoder. One accepted instruction per two cycles at peak.
// Optional build macro: IFETCH_JAL_PREDICT_EN enables JAL target prediction.
module instruction_fetcher #(
    parameter int unsigned IFQ_DEPTH_LOG = 2,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] req_pc,
    input  logic [31:0] inst_in,
    input  logic        inst_valid_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pred_pc
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 1 << IFQ_DEPTH_LOG;
    localparam int unsigned CNT_W = IFQ_DEPTH_LOG + 1;

    logic [XLEN-1:0]          pc_q, pc_d;
    logic [XLEN-1:0]          last_pc_q, last_pc_d;
    logic                     last_vld_q, last_vld_d;
    logic [IFQ_DEPTH_LOG-1:0] head_q, head_d;
    logic [IFQ_DEPTH_LOG-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    // Queue storage; deliberately not reset, only the pointers are.
    logic [XLEN-1:0] ent_pc_q   [DEPTH];
    logic [XLEN-1:0] ent_inst_q [DEPTH];
    logic [XLEN-1:0] ent_pred_q [DEPTH];

    logic            full_c;
    logic            accept_c;
    logic            deq_c;
    logic [XLEN-1:0] next_pc_c;

    assign req_pc      = pc_q;
    assign out_valid   = (count_q != '0);
    assign out_inst    = ent_inst_q[head_q];
    assign out_pc      = ent_pc_q[head_q];
    assign out_pred_pc = ent_pred_q[head_q];

    // Accept/dequeue qualification; flush overrides both.
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        accept_c = inst_valid_in && last_vld_q && (last_pc_q == pc_q)
                   && !full_c && !flush_in;
        deq_c    = out_valid && out_ready && !flush_in;
    end

    // Predicted next fetch address for the instruction being accepted.
    always_comb begin
        next_pc_c = pc_q + XLEN'(4);
`ifdef IFETCH_JAL_PREDICT_EN
        if (inst_in[6:0] == 7'b1101111) begin
            next_pc_c = pc_q + {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                                inst_in[20], inst_in[30:21], 1'b0};
        end
`endif
    end

    // Next-state for fetch PC, request tracking and queue pointers.
    always_comb begin
        pc_d       = pc_q;
        last_pc_d  = pc_q;
        last_vld_d = 1'b1;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush_in) begin
            pc_d       = flush_pc;
            last_vld_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (accept_c) begin
                pc_d       = next_pc_c;
                last_vld_d = 1'b0;
                tail_d     = tail_q + IFQ_DEPTH_LOG'(1);
            end
            if (deq_c) begin
                head_d = head_q + IFQ_DEPTH_LOG'(1);
            end
            count_d = count_q + CNT_W'(accept_c) - CNT_W'(deq_c);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_q       <= RESET_PC;
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue entry write at the tail on accept.
    always_ff @(posedge clk_in) begin
        if (accept_c) begin
            ent_pc_q[tail_q]   <= pc_q;
            ent_inst_q[tail_q] <= inst_in;
            ent_pred_q[tail_q] <= next_pc_c;
        end
    end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 The block SHALL have one clock, clk_in; reset rst_in SHALL be asynchronous and active-low.
REQ-002 The block SHALL have parameter IFQ_DEPTH_LOG, default 2: fetch-queue depth is 2^IFQ_DEPTH_LOG entries.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0: the first fetch address after reset.
REQ-004 The block SHALL have the following ports (name  direction  width  meaning):
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-low reset
- req_pc  output  32  fetch address to the instruction cache
- inst_in  input  32  instruction word from the cache, registered, for last cycle's req_pc
- inst_valid_in  input  1  inst_in is valid
- flush_in  input  1  redirect request from the back end
- flush_pc  input  32  redirect target
- out_ready  input  1  decoder accepts the queue head this cycle
- out_valid  output  1  queue non-empty
- out_inst  output  32  instruction at the queue head
- out_pc  output  32  PC of the queue head
- out_pred_pc  output  32  predicted next PC of the queue head

Function
REQ-005 The block SHALL hold fetch PC register pc, and req_pc SHALL equal pc combinationally.
REQ-006 The block SHALL keep register last_pc and flag last_vld, recording each cycle the req_pc presented and whether that request is still live.
REQ-007 An accept SHALL occur when all of the following hold: inst_valid_in, last_vld, last_pc == pc, queue not full, and flush_in low.
REQ-008 On accept, the block SHALL enqueue {pc, inst_in, next_pc} and set pc <= next_pc at the same edge.
REQ-009 After an accept, last_vld SHALL be 0 for the next cycle, so the stale cache response is ignored; peak throughput is 1 instruction per 2 cycles.
REQ-010 When no accept occurs, pc SHALL hold and req_pc SHALL remain stable until an accept or flush.
REQ-011 next_pc SHALL be pc + 4 (32-bit, wrap modulo 2^32) unless REQ-021 applies.
REQ-012 The queue SHALL be a circular buffer with head/tail pointers of width IFQ_DEPTH_LOG and a count of width IFQ_DEPTH_LOG+1; pointers SHALL wrap naturally.
REQ-013 out_valid SHALL equal (count != 0), and out_inst, out_pc and out_pred_pc SHALL be read combinationally from the head entry.
REQ-014 A dequeue SHALL occur when out_valid && out_ready.
REQ-015 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-016 When full, the block SHALL NOT enqueue, even if a dequeue happens in the same cycle.
REQ-017 When empty, out_ready SHALL be ignored.
REQ-018 flush_in SHALL take priority over enqueue and dequeue: at the edge, the queue empties (count = 0, head = tail = 0), pc <= flush_pc, and last_vld <= 0.
REQ-019 After a flush, the first accept SHALL be possible no earlier than 2 cycles after the flush edge.

Reset
REQ-020 While rst_in = 0, the block SHALL asynchronously set: pc = RESET_PC, last_pc = 0, last_vld = 0, head = tail = count = 0, out_valid = 0; queue storage SHALL NOT be reset. Fetching SHALL resume on the first edge after rst_in rises; reset mid-fetch SHALL discard any in-flight response.

Configuration
REQ-021 With macro IFETCH_JAL_PREDICT_EN defined, an accepted instruction with inst_in[6:0] == 7'b1101111 (JAL) SHALL give next_pc = pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), and this value SHALL be stored as out_pred_pc.
REQ-022 Without IFETCH_JAL_PREDICT_EN, next_pc SHALL always be pc + 4, and no decode logic SHALL be synthesised.

Verification
REQ-023 Sequential fetch: reset with RESET_PC = 0; cache returns valid on every request; out_ready = 1 -> out_pc sequence 0, 4, 8, 12, with one instruction per 2 cycles.
REQ-024 Back-pressure: out_ready = 0 with 4 instructions accepted -> count = 4, req_pc held at 0x10; raising out_ready for 1 cycle -> one dequeue and no enqueue that cycle.
REQ-025 Flush: queue holds 3 entries, flush_in = 1 with flush_pc = 0x200 -> next cycle out_valid = 0, req_pc = 0x200; a stale inst_valid_in the cycle after flush is not enqueued.
REQ-026 Cache miss: inst_valid_in held 0 for 20 cycles -> req_pc stable and no enqueue; the first valid with matching last_pc is enqueued.
REQ-027 JAL (macro on): at pc 0x100, inst 0x0100006F (jal x0, +16) -> out_pred_pc = 0x110, next req_pc = 0x110; with macro off -> 0x104.
REQ-028 Async reset mid-fetch: rst_in = 0 between edges -> out_valid = 0 and req_pc = RESET_PC immediately, without waiting for a clock edge.
